// File: rtl/regfile_dbg_pkg.sv
// Shared definitions for the register-file debug dump reader.
package regfile_dbg_pkg;

    localparam int unsigned REG_W    = 64;
    localparam int unsigned IDX_W    = 5;
    localparam int unsigned ZERO_REG = 31;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SEND_A,
        SEND_B
    } dumpState_e;

endpackage

// File: rtl/regfile_dump.sv
// regfile_dump: walks the CPU register file two registers per fetch through
// its read ports and streams {index, value} words over a valid/ready link.
// The CPU is stalled (HoldCpu) for the whole walk.
//
// Ports:
//   Clk, Reset         clock, synchronous active-high reset
//   Start              one-cycle dump request, honoured only in IDLE
//   RA, RB             read addresses (even / odd register of the pair)
//   BusA, BusB         register file read data for RA / RB
//   DumpData, DumpIdx  streamed value and its register number
//   DumpValid          word valid; DumpReady accepts it at a posedge
//   Busy, HoldCpu      dump in progress / CPU stall (identical)
//   Done               one-cycle pulse after the last word is accepted
module regfile_dump
    import regfile_dbg_pkg::*;
#(
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned DATA_W   = REG_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    output logic [IDX_W-1:0]  RA,
    output logic [IDX_W-1:0]  RB,
    input  logic [DATA_W-1:0] BusA,
    input  logic [DATA_W-1:0] BusB,
    output logic [DATA_W-1:0] DumpData,
    output logic [IDX_W-1:0]  DumpIdx,
    output logic              DumpValid,
    input  logic              DumpReady,
    output logic              Busy,
    output logic              HoldCpu,
    output logic              Done
);

    localparam logic [IDX_W-1:0] LAST_RB = IDX_W'(NUM_REGS - 1);

    dumpState_e        state;
    // DumpData itself holds the even word until it is sent, so only the odd
    // word needs a separate capture register.
    logic [DATA_W-1:0] bufB;

    wire xfer = DumpValid & DumpReady;

    // Dump sequencer with registered outputs.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            RA        <= '0;
            RB        <= IDX_W'(1);
            bufB      <= '0;
            DumpData  <= '0;
            DumpIdx   <= '0;
            DumpValid <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        RA    <= '0;
                        RB    <= IDX_W'(1);
                        Busy  <= 1'b1;
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    // Read addresses have settled for a full cycle; capture both.
                    bufB      <= BusB;
                    DumpData  <= BusA;
                    DumpIdx   <= RA;
                    DumpValid <= 1'b1;
                    state     <= SEND_A;
                end
                SEND_A: begin
                    if (xfer) begin
                        DumpData <= bufB;
                        DumpIdx  <= RB;
                        state    <= SEND_B;
                    end
                end
                SEND_B: begin
                    if (xfer) begin
                        DumpValid <= 1'b0;
                        if (RB == LAST_RB) begin
                            Done  <= 1'b1;
                            Busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            RA    <= RA + IDX_W'(2);
                            RB    <= RB + IDX_W'(2);
                            state <= FETCH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign HoldCpu = Busy;

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump: register file model, expected word
// stream built from a snapshot of the registers at Start.
module tb_regfile_dump;
    import regfile_dbg_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // 32-register instance
    logic        start;
    logic [4:0]  ra, rb, dumpIdx;
    logic [63:0] busA, busB, dumpData;
    logic        dumpValid, dumpReady, busy, holdCpu, done;

    // 4-register instance
    logic        start4;
    logic [4:0]  ra4, rb4, dumpIdx4;
    logic [63:0] busA4, busB4, dumpData4;
    logic        dumpValid4, dumpReady4, busy4, holdCpu4, done4;

    logic [63:0] regs [32];

    int nCompared = 0;
    int nMismatch = 0;

    // Register file read ports; X31 is hardwired to zero.
    assign busA  = (ra  == IDX_W'(ZERO_REG)) ? 64'h0 : regs[ra];
    assign busB  = (rb  == IDX_W'(ZERO_REG)) ? 64'h0 : regs[rb];
    assign busA4 = (ra4 == IDX_W'(ZERO_REG)) ? 64'h0 : regs[ra4];
    assign busB4 = (rb4 == IDX_W'(ZERO_REG)) ? 64'h0 : regs[rb4];

    regfile_dump #(.NUM_REGS(32), .DATA_W(64)) u32 (
        .Clk(clk), .Reset(rst), .Start(start), .RA(ra), .RB(rb),
        .BusA(busA), .BusB(busB), .DumpData(dumpData), .DumpIdx(dumpIdx),
        .DumpValid(dumpValid), .DumpReady(dumpReady), .Busy(busy),
        .HoldCpu(holdCpu), .Done(done)
    );

    regfile_dump #(.NUM_REGS(4), .DATA_W(64)) u4 (
        .Clk(clk), .Reset(rst), .Start(start4), .RA(ra4), .RB(rb4),
        .BusA(busA4), .BusB(busB4), .DumpData(dumpData4), .DumpIdx(dumpIdx4),
        .DumpValid(dumpValid4), .DumpReady(dumpReady4), .Busy(busy4),
        .HoldCpu(holdCpu4), .Done(done4)
    );

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatch++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input bit rnd);
        for (int i = 0; i < 32; i++)
            regs[i] = rnd ? {$urandom, $urandom} : 64'h1000 + 64'(i);
    endtask

    task automatic checkResetOutputs(input string pfx);
        checkVal({pfx, "_ra"},    64'(ra), 64'd0);
        checkVal({pfx, "_rb"},    64'(rb), 64'd1);
        checkVal({pfx, "_data"},  dumpData, 64'd0);
        checkVal({pfx, "_idx"},   64'(dumpIdx), 64'd0);
        checkVal({pfx, "_valid"}, 64'(dumpValid), 64'd0);
        checkVal({pfx, "_busy"},  64'(busy), 64'd0);
        checkVal({pfx, "_hold"},  64'(holdCpu), 64'd0);
        checkVal({pfx, "_done"},  64'(done), 64'd0);
    endtask

    // mode 0: ready always 1; 1: random ready; 2: 5-cycle stall on idx 3.
    // pokeWord >= 0 re-pulses Start while that word is on the bus.
    task automatic runDump32(input int mode, input int pokeWord, input bit checkTotal);
        logic [63:0] eD[$];
        int          eI[$];
        int          e, words, lastX, stallCnt;
        bit          sawDone, stalledPrev;
        logic [63:0] prevD;
        logic [4:0]  prevI;
        for (int i = 0; i < 32; i++) begin
            eI.push_back(i);
            eD.push_back((i == 31) ? 64'h0 : regs[i]);
        end
        @(negedge clk);
        start = 1'b1;
        dumpReady = 1'b1;
        @(negedge clk);
        start = 1'b0;
        e = 0; words = 0; lastX = -1; stallCnt = 0;
        sawDone = 1'b0; stalledPrev = 1'b0; prevD = '0; prevI = '0;
        while (e < 400) begin
            if (done) begin
                sawDone = 1'b1;
                break;
            end
            checkVal("busy_during_dump", 64'(busy), 64'd1);
            checkVal("holdcpu_during_dump", 64'(holdCpu), 64'd1);
            if (stalledPrev) begin
                checkVal("stall_valid_held", 64'(dumpValid), 64'd1);
                checkVal("stall_data_held", dumpData, prevD);
                checkVal("stall_idx_held", 64'(dumpIdx), 64'(prevI));
            end
            start = (pokeWord >= 0 && words == pokeWord && dumpValid) ? 1'b1 : 1'b0;
            if (dumpValid) begin
                if (eI.size() == 0) begin
                    checkVal("extra_word", 64'd1, 64'd0);
                    break;
                end
                checkVal("word_idx", 64'(dumpIdx), 64'(eI[0]));
                checkVal("word_data", dumpData, eD[0]);
                case (mode)
                    1: dumpReady = ($urandom_range(0, 99) < 70);
                    2: begin
                        if (dumpIdx == 5'd3 && stallCnt < 5) begin
                            dumpReady = 1'b0;
                            stallCnt++;
                            checkVal("stall_idx3_data", dumpData, 64'h1003);
                        end else begin
                            dumpReady = 1'b1;
                        end
                    end
                    default: dumpReady = 1'b1;
                endcase
                if (dumpReady) begin
                    void'(eI.pop_front());
                    void'(eD.pop_front());
                    words++;
                    lastX = e + 1;
                end
                stalledPrev = !dumpReady;
                prevD = dumpData;
                prevI = dumpIdx;
            end else begin
                dumpReady = ($urandom_range(0, 1) == 1);
                stalledPrev = 1'b0;
            end
            @(negedge clk);
            e++;
        end
        start = 1'b0;
        checkVal("done_seen", 64'(sawDone), 64'd1);
        if (sawDone) begin
            checkVal("word_count", 64'(words), 64'd32);
            checkVal("done_after_last_xfer", 64'(e), 64'(lastX));
            checkVal("busy_in_done_cycle", 64'(busy), 64'd0);
            checkVal("holdcpu_in_done_cycle", 64'(holdCpu), 64'd0);
            checkVal("valid_in_done_cycle", 64'(dumpValid), 64'd0);
            if (checkTotal) checkVal("start_to_done_cycles", 64'(e), 64'd48);
            if (mode == 2) checkVal("stall_cycles", 64'(stallCnt), 64'd5);
            @(negedge clk);
            checkVal("done_single_pulse", 64'(done), 64'd0);
            checkVal("idle_after_done", 64'(busy), 64'd0);
        end
    endtask

    task automatic resetMidDump();
        int n;
        preload(1'b0);
        @(negedge clk);
        start = 1'b1;
        dumpReady = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(dumpValid && dumpIdx == 5'd7) && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkVal("reached_idx7", 64'(n < 200), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        checkResetOutputs("midreset");
        rst = 1'b0;
        @(negedge clk);
        checkVal("no_done_after_abort", 64'(done), 64'd0);
        checkVal("no_valid_after_abort", 64'(dumpValid), 64'd0);
    endtask

    task automatic smallDump();
        logic [63:0] eD[$];
        int          words, n;
        bit          written, sawDone;
        preload(1'b0);
        for (int i = 0; i < 4; i++) eD.push_back(64'h1000 + 64'(i));
        @(negedge clk);
        start4 = 1'b1;
        dumpReady4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        words = 0; n = 0; written = 1'b0; sawDone = 1'b0;
        while (n < 100) begin
            if (done4) begin
                sawDone = 1'b1;
                break;
            end
            if (dumpValid4) begin
                // Pair {X2,X3} is already captured once X2 is on the bus.
                if (dumpIdx4 == 5'd2 && !written) begin
                    regs[2] = 64'hDEAD;
                    written = 1'b1;
                end
                if (eD.size() == 0) begin
                    checkVal("n4_extra_word", 64'd1, 64'd0);
                    break;
                end
                checkVal("n4_idx", 64'(dumpIdx4), 64'(words));
                checkVal("n4_data", dumpData4, eD[0]);
                void'(eD.pop_front());
                words++;
            end
            @(negedge clk);
            n++;
        end
        checkVal("n4_done_seen", 64'(sawDone), 64'd1);
        checkVal("n4_word_count", 64'(words), 64'd4);
        checkVal("n4_busy_at_done", 64'(busy4), 64'd0);
        @(negedge clk);
        checkVal("n4_done_single_pulse", 64'(done4), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        start4 = 1'b0;
        dumpReady = 1'b0;
        dumpReady4 = 1'b0;
        preload(1'b0);
        repeat (2) @(negedge clk);
        checkResetOutputs("reset");
        rst = 1'b0;

        preload(1'b0);
        runDump32(0, -1, 1'b1);
        runDump32(2, -1, 1'b0);
        runDump32(0, 10, 1'b1);
        resetMidDump();
        runDump32(0, -1, 1'b1);
        for (int k = 0; k < 3; k++) begin
            preload(1'b1);
            runDump32(1, (k == 1) ? 5 : -1, 1'b0);
        end
        smallDump();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule

// File: doc/regfile_dump.md
Name: regfile_dump

Overview:
- Debug reader for the 32x64 CPU register file.
- On a Start pulse it walks the register file through its two read ports (RA/RB, BusA/BusB), two registers per fetch.
- It streams each 64-bit value with its index over a valid/ready handshake to the debug/trace path.
- It asserts HoldCpu for the whole dump, so the datapath issues no RegWr during the walk.

Parameters:
- NUM_REGS, 32, number of registers dumped starting at X0; must be even, 2..32; X31 is included at 32 and reads 0.
- DATA_W, 64, register width; must match BusA/BusB.

Ports:
- Clk  input  1  system clock; all state updates on the posedge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  one-cycle request to begin a dump; sampled only in IDLE.
- RA  output  5  read address A to the register file (even index).
- RB  output  5  read address B to the register file (odd index).
- BusA  input  DATA_W  register file read data for RA (combinational, settles within the cycle).
- BusB  input  DATA_W  register file read data for RB.
- DumpData  output  DATA_W  streamed register value.
- DumpIdx  output  5  register number of DumpData.
- DumpValid  output  1  DumpData/DumpIdx valid.
- DumpReady  input  1  sink accepts the word; transfer = DumpValid & DumpReady at a posedge.
- Busy  output  1  dump in progress.
- HoldCpu  output  1  stall request to the CPU; equals Busy.
- Done  output  1  one-cycle pulse when the last word has been accepted.

Behaviour:
- Clock and reset:
  - One clock; reset is synchronous and active-high.
  - Clock port is named Clk and reset port is named Reset.
- Reset values:
  - State is IDLE.
  - RA=0, RB=1.
  - DumpData=0, DumpIdx=0.
  - DumpValid=0, Busy=0, HoldCpu=0, Done=0.
  - Reset mid-dump aborts immediately; no Done pulse is produced.
- IDLE: Start=1 at edge t0 -> FETCH, with RA=0, RB=1, Busy=1 registered at t0. Start=0 -> stay in IDLE.
- FETCH: one cycle for the address to settle. At the next edge:
  - bufA<=BusA, bufB<=BusB.
  - DumpData<=BusA, DumpIdx<=RA, DumpValid<=1.
  - Go to SEND_A.
- Start-to-valid latency: DumpValid is first high in the second cycle after the Start edge, i.e. after edge t1.
- SEND_A: hold all outputs until transfer. On transfer: DumpData<=bufB, DumpIdx<=RB, go to SEND_B.
- SEND_B, on transfer:
  - If RB == NUM_REGS-1: DumpValid<=0, Done<=1, Busy<=0, go to IDLE.
  - Else: RA<=RA+2, RB<=RB+2, DumpValid<=0, go to FETCH.
- DumpValid timing: it drops for exactly one cycle between pairs (the FETCH cycle). Sustained throughput is 2 words per 3 cycles.
- Done timing: Done is high for exactly the one cycle following the final transfer, and Busy is already 0 in that cycle.
- Back-pressure: while DumpValid=1 and DumpReady=0, DumpData and DumpIdx are held stable. Valid never drops without a transfer, except on Reset.
- Start while Busy is ignored; it is not queued.
- Start in the same cycle that Done is high is accepted, because the state is already IDLE.
- Captured values are bufA/bufB. Register file changes after capture do not affect the words streamed.
- Index arithmetic is 5-bit unsigned. Because NUM_REGS is even, the maximum RB is 31 and there is no wrap.
- RA and RB are driven continuously; in IDLE they keep their last value except after Reset.

Decomposition:
- Shared package regfile_dbg_pkg holds:
  - the state encoding: IDLE, FETCH, SEND_A, SEND_B;
  - REG_W=64;
  - IDX_W=5;
  - ZERO_REG=31.
- No sub-module: a single FSM with a two-entry capture buffer.

Test Plan:
- Preload Xn=64'h1000+n (n=0..30), DumpReady tied 1, pulse Start -> 32 words, idx 0..31 in order, data 64'h1000..64'h101E, then idx 31 data 0. Done pulses once, 1 cycle after the last transfer. Total 48 cycles from the Start edge to Done.
- Back-pressure: DumpReady=0 for 5 cycles while idx 3 is valid -> DumpData=64'h1003 and idx=3 held stable all 5 cycles; no word is lost or duplicated.
- Start re-pulsed at word 10 -> ignored; the dump completes with 32 words and a single Done.
- Reset asserted while in SEND_B at idx 7 -> next cycle all outputs are at reset values with no Done. A new Start restarts at idx 0.
- NUM_REGS=4, X2 written to 64'hDEAD after its pair was captured -> streamed value is the captured 64'h1002. Exactly 4 words, then Done.
- HoldCpu check: HoldCpu=1 from the cycle after the Start edge through the final transfer cycle, and 0 in the Done cycle.
